// File: rtl/gb_cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : gb_cpu_fetch
// Brief    : Game Boy CPU opcode fetch stage. Owns the program counter, reads
//            opcode bytes, folds a 0xCB prefix into a second fetch and hands
//            {opcode, cb_prefix} to the sequencer over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module gb_cpu_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  ir_opcode,
  output logic        ir_cb_prefix,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic        fetch_next,
  output logic [15:0] pc
);

  localparam logic [7:0] c_CB_PREFIX = 8'hCB;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_CB_FETCH = 3'd2,
    S_VALID    = 3'd3,
    S_EXEC     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] w_pc_nxt;
  logic [7:0]  w_opcode_nxt;
  logic        w_cb_nxt;
  logic        w_valid_nxt;

  // Bus request is purely a function of state; address is always the PC.
  assign mem_rd   = (r_state == S_FETCH) || (r_state == S_CB_FETCH);
  assign mem_addr = pc;

  // Next-state and datapath updates; a PC redirect overrides everything else.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = pc;
    w_opcode_nxt = ir_opcode;
    w_cb_nxt     = ir_cb_prefix;
    w_valid_nxt  = ir_valid;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          w_pc_nxt = pc + 16'd1;
          if (mem_rdata == c_CB_PREFIX) begin
            w_state_nxt = S_CB_FETCH;
          end else begin
            w_opcode_nxt = mem_rdata;
            w_cb_nxt     = 1'b0;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_VALID;
          end
        end
      end
      S_CB_FETCH: begin
        // A second CB byte here is a real CB-page opcode, not another prefix.
        if (mem_ready) begin
          w_pc_nxt     = pc + 16'd1;
          w_opcode_nxt = mem_rdata;
          w_cb_nxt     = 1'b1;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_VALID;
        end
      end
      S_VALID: begin
        if (ir_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (pc_inc)     w_pc_nxt    = pc + 16'd1;
        if (fetch_next) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Redirect: drop any byte returned this cycle and refetch from the target.
    if (pc_load && (r_state != S_IDLE)) begin
      w_pc_nxt     = pc_load_val;
      w_opcode_nxt = ir_opcode;
      w_cb_nxt     = ir_cb_prefix;
      w_valid_nxt  = 1'b0;
      w_state_nxt  = S_FETCH;
    end
  end

  // State, PC and instruction register; async reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      pc           <= RESET_PC;
      ir_opcode    <= 8'h00;
      ir_cb_prefix <= 1'b0;
      ir_valid     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      pc           <= w_pc_nxt;
      ir_opcode    <= w_opcode_nxt;
      ir_cb_prefix <= w_cb_nxt;
      ir_valid     <= w_valid_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_cpu_fetch
// Brief    : Directed self-checking bench for gb_cpu_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_cpu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [7:0]  ir_opcode;
  logic        ir_cb_prefix;
  logic        ir_valid;
  logic        ir_ready;
  logic        pc_inc;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        fetch_next;
  logic [15:0] pc;

  logic [7:0] mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Zero-wait memory model: data follows the address combinationally.
  assign mem_rdata = mem[mem_addr];

  gb_cpu_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir_opcode(ir_opcode), .ir_cb_prefix(ir_cb_prefix), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val), .fetch_next(fetch_next),
    .pc(pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From EXEC: redirect to target and start fetching there.
  task automatic redirect(input logic [15:0] target);
    pc_load = 1'b1; pc_load_val = target; fetch_next = 1'b1;
    step();
    pc_load = 1'b0; fetch_next = 1'b0;
  endtask

  // From VALID: accept the instruction, landing in EXEC.
  task automatic accept();
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({mem_rd, pc, ir_valid, ir_opcode, ir_cb_prefix} !== {1'b0, 16'h0000, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: rd=%b pc=%h v=%b op=%h cb=%b, want 0 0000 0 00 0",
               mem_rd, pc, ir_valid, ir_opcode, ir_cb_prefix);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0000}) begin
      n_bad++;
      $display("FAIL first_fetch: rd=%b addr=%h, want 1 0000", mem_rd, mem_addr);
    end
    step();
    n_cmp++;
    if ({ir_valid, ir_opcode, ir_cb_prefix, pc, mem_rd} !== {1'b1, 8'h00, 1'b0, 16'h0001, 1'b0}) begin
      n_bad++;
      $display("FAIL first_valid: v=%b op=%h cb=%b pc=%h rd=%b, want 1 00 0 0001 0",
               ir_valid, ir_opcode, ir_cb_prefix, pc, mem_rd);
    end
    accept();
    n_cmp++;
    if ({ir_valid, mem_rd} !== 2'b00) begin
      n_bad++;
      $display("FAIL accept_exec: v=%b rd=%b, want 0 0", ir_valid, mem_rd);
    end
  endtask

  task automatic test_cb_prefix();
    redirect(16'h0100);
    n_cmp++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0100}) begin
      n_bad++;
      $display("FAIL cb_read1: rd=%b addr=%h, want 1 0100", mem_rd, mem_addr);
    end
    step();
    n_cmp++;
    if ({mem_rd, mem_addr, ir_valid} !== {1'b1, 16'h0101, 1'b0}) begin
      n_bad++;
      $display("FAIL cb_read2: rd=%b addr=%h v=%b, want 1 0101 0", mem_rd, mem_addr, ir_valid);
    end
    step();
    n_cmp++;
    if ({ir_valid, ir_opcode, ir_cb_prefix, pc} !== {1'b1, 8'h37, 1'b1, 16'h0102}) begin
      n_bad++;
      $display("FAIL cb_valid: v=%b op=%h cb=%b pc=%h, want 1 37 1 0102",
               ir_valid, ir_opcode, ir_cb_prefix, pc);
    end
  endtask

  task automatic test_valid_stall();
    // Sequencer holds off; stray pc_inc/fetch_next must be ignored in VALID.
    pc_inc = 1'b1; fetch_next = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({ir_valid, ir_opcode, ir_cb_prefix, pc, mem_rd} !== {1'b1, 8'h37, 1'b1, 16'h0102, 1'b0}) begin
        n_bad++;
        $display("FAIL valid_stall[%0d]: v=%b op=%h cb=%b pc=%h rd=%b, want 1 37 1 0102 0",
                 i, ir_valid, ir_opcode, ir_cb_prefix, pc, mem_rd);
      end
    end
    pc_inc = 1'b0; fetch_next = 1'b0;
    accept();
    n_cmp++;
    if ({ir_valid, mem_rd, pc} !== {1'b0, 1'b0, 16'h0102}) begin
      n_bad++;
      $display("FAIL stall_accept: v=%b rd=%b pc=%h, want 0 0 0102", ir_valid, mem_rd, pc);
    end
  endtask

  task automatic test_pc_inc_load();
    redirect(16'h0200);
    step();                      // fetch 00 at 0200 -> pc 0201
    accept();
    pc_inc = 1'b1;
    step(); step();
    pc_inc = 1'b0;
    n_cmp++;
    if ({pc, mem_rd} !== {16'h0203, 1'b0}) begin
      n_bad++;
      $display("FAIL pc_inc_x2: pc=%h rd=%b, want 0203 0", pc, mem_rd);
    end
    fetch_next = 1'b1;
    step();
    fetch_next = 1'b0;
    n_cmp++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0203}) begin
      n_bad++;
      $display("FAIL fetch_after_inc: rd=%b addr=%h, want 1 0203", mem_rd, mem_addr);
    end
    step();
    accept();
    pc_load = 1'b1; pc_load_val = 16'hC000; pc_inc = 1'b1;
    step();
    pc_load = 1'b0; pc_inc = 1'b0;
    n_cmp++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'hC000}) begin
      n_bad++;
      $display("FAIL load_over_inc: rd=%b addr=%h, want 1 C000", mem_rd, mem_addr);
    end
    step();
    accept();
  endtask

  task automatic test_pc_wrap();
    redirect(16'hFFFF);
    step();
    n_cmp++;
    if ({ir_valid, ir_opcode, ir_cb_prefix, pc} !== {1'b1, 8'h3C, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL pc_wrap: v=%b op=%h cb=%b pc=%h, want 1 3C 0 0000",
               ir_valid, ir_opcode, ir_cb_prefix, pc);
    end
    accept();
  endtask

  task automatic test_load_in_fetch_and_reset();
    mem_ready = 1'b0;
    redirect(16'h0300);
    step();
    n_cmp++;
    if ({mem_rd, mem_addr, ir_valid} !== {1'b1, 16'h0300, 1'b0}) begin
      n_bad++;
      $display("FAIL wait_state: rd=%b addr=%h v=%b, want 1 0300 0", mem_rd, mem_addr, ir_valid);
    end
    mem_ready = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0038;
    step();
    pc_load = 1'b0;
    n_cmp++;
    if ({ir_valid, ir_opcode, mem_rd, mem_addr} !== {1'b0, 8'h3C, 1'b1, 16'h0038}) begin
      n_bad++;
      $display("FAIL load_drop: v=%b op=%h rd=%b addr=%h, want 0 3C 1 0038",
               ir_valid, ir_opcode, mem_rd, mem_addr);
    end
    step();                      // CB at 0038 -> CB_FETCH
    n_cmp++;
    if ({mem_rd, mem_addr, ir_valid} !== {1'b1, 16'h0039, 1'b0}) begin
      n_bad++;
      $display("FAIL in_cb_fetch: rd=%b addr=%h v=%b, want 1 0039 0", mem_rd, mem_addr, ir_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rd, mem_addr, pc, ir_valid, ir_opcode, ir_cb_prefix} !==
        {1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: rd=%b addr=%h pc=%h v=%b op=%h cb=%b, want 0 0000 0000 0 00 0",
               mem_rd, mem_addr, pc, ir_valid, ir_opcode, ir_cb_prefix);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'hCB;
    mem[16'h0101] = 8'h37;
    mem[16'hFFFF] = 8'h3C;
    mem[16'h0300] = 8'h3E;
    mem[16'h0038] = 8'hCB;
    mem[16'h0039] = 8'h11;
    rst_n = 1'b0; mem_ready = 1'b1; ir_ready = 1'b0; pc_inc = 1'b0;
    pc_load = 1'b0; pc_load_val = 16'h0000; fetch_next = 1'b0;

    test_reset();
    test_cb_prefix();
    test_valid_stall();
    test_pc_inc_load();
    test_pc_wrap();
    test_load_in_fetch_and_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gb_cpu_fetch.md
# gb_cpu_fetch

Opcode fetch stage for the Game Boy CPU, sitting directly upstream of `gb_cpu_decoder`. It owns the program counter and reads opcode bytes from the memory bus. It folds a `0xCB` prefix byte into a second fetch and presents an `{opcode, cb_prefix}` pair to the decoder/sequencer through a valid/ready handshake. While an instruction executes, the sequencer may advance or redirect the PC (immediate consumption, jumps, calls, returns) before requesting the next fetch.

## Interface

Parameters:
- `RESET_PC`, default `16'h0000`: PC value loaded on reset.

Ports (name, direction, width, meaning):
- `clk` in 1: CPU clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_addr` out 16: fetch address; always equals `pc`.
- `mem_rd` out 1: fetch read request.
- `mem_rdata` in 8: read data; valid when `mem_ready` is high.
- `mem_ready` in 1: read completes at this clock edge.
- `ir_opcode` out 8: fetched opcode (the byte after `CB` when prefixed).
- `ir_cb_prefix` out 1: opcode was `0xCB`-prefixed.
- `ir_valid` out 1: `ir_opcode`/`ir_cb_prefix` are valid.
- `ir_ready` in 1: sequencer accepts the instruction.
- `pc_inc` in 1: increment PC by 1 (immediate byte consumed); honoured in EXEC only.
- `pc_load` in 1: load PC with `pc_load_val`; honoured in any non-IDLE state.
- `pc_load_val` in 16: redirect target.
- `fetch_next` in 1: current instruction done; start the next fetch.
- `pc` out 16: current program counter.

## Operation

- States: IDLE, FETCH, CB_FETCH, VALID, EXEC.
- Reset (async, `rst_n` low):
  - State IDLE, `pc`=`RESET_PC`, `ir_opcode`=`8'h00`, `ir_cb_prefix`=0, `ir_valid`=0, `mem_rd`=0.
- IDLE: unconditionally moves to FETCH on the next edge.
- FETCH: `mem_rd`=1, `mem_addr`=`pc`.
  - On an edge with `mem_ready`=1, `pc` increments by 1.
  - If `mem_rdata`=`8'hCB`, go to CB_FETCH.
  - Otherwise latch `ir_opcode`=`mem_rdata`, set `ir_cb_prefix`=0, go to VALID.
- CB_FETCH: `mem_rd`=1.
  - On `mem_ready`: `pc`+1, latch `ir_opcode`=`mem_rdata`, set `ir_cb_prefix`=1, go to VALID.
  - A second `0xCB` is latched as opcode `CB` (CB-page `set 1,e`), not as another prefix.
- VALID:
  - `ir_valid`=1 (registered); `mem_rd`=0.
  - `ir_opcode` and `ir_cb_prefix` hold stable until accepted.
  - On `ir_valid`&&`ir_ready`, go to EXEC and clear `ir_valid`.
- EXEC: `mem_rd`=0; `ir_opcode`/`ir_cb_prefix` hold their last values.
  - `pc_inc` gives `pc`+1.
  - `fetch_next` gives FETCH.
- `pc_load` in FETCH, CB_FETCH, VALID or EXEC:
  - `pc`<=`pc_load_val`.
  - State goes to FETCH, `ir_valid` clears, and any byte returned that cycle is discarded.
- Priority: `pc_load` > `pc_inc`. `pc_load` together with `fetch_next` gives FETCH from the loaded PC.
- PC arithmetic is modulo 2^16: `16'hFFFF`+1 wraps to `16'h0000`.
- `pc_inc`, `fetch_next` and `ir_ready` outside their honoured states are ignored.

## Timing

- `mem_rd` and `mem_addr` are combinational from state/`pc`; `mem_addr` is stable while `mem_rd` is high, except on `pc_load`.
- Latency:
  - Unprefixed instruction with zero-wait memory: FETCH edge, then `ir_valid` high in the following cycle, i.e. 1 cycle after entering FETCH.
  - Prefixed instruction: 2 cycles.
  - Each `mem_ready`-low cycle adds one cycle.
- After reset release, the first `mem_rd` asserts one cycle later (IDLE→FETCH).
- `ir_valid` never asserts in the same cycle as `mem_rd`.
- Reset mid-operation aborts immediately; there is no partial-state retention.

## Test plan

- Reset, memory `0000:00`, zero-wait → `mem_rd` at cycle 1, `mem_addr`=`0000`; `ir_valid` with opcode `00`, cb=0; `pc`=`0001`.
- Memory `0100:CB 37`, `RESET_PC`=`0100` → two reads at `0100` and `0101`; `ir_opcode`=`37`, `ir_cb_prefix`=1, `pc`=`0102`.
- `ir_ready` low for 3 cycles in VALID → `ir_valid`, `ir_opcode` and `pc` stable; no `mem_rd`; accepted on the 4th cycle → EXEC.
- EXEC, `pc`=`0201`, `pc_inc` ×2 then `fetch_next` → next fetch at `0203`. Repeat with `pc_load`=`C000` plus `pc_inc` in the same cycle → next fetch at `C000`.
- `pc`=`FFFF`, byte `3C` returned → `pc`=`0000`, opcode `3C`.
- FETCH with `mem_ready` low, then `pc_load`=`0038` while `mem_ready`=1 → returned byte dropped, `ir_valid` stays 0, next `mem_addr`=`0038`. Assert `rst_n` low in CB_FETCH → all outputs at reset values immediately.
